// File: rtl/score_pkg.sv
// Shared score-path definitions: widths, converter FSM states and the double-dabble nibble step.
// Used by the score counter, this keeper and the display driver.
package score_pkg;

  localparam int SCORE_W    = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } bcd_state_t;

  // One BCD digit's pre-shift correction: 4-bit result, no carry out of the nibble.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE -> LOAD -> SHIFT x WIDTH -> DONE.
// bcd holds the last complete result; done pulses in the cycle bcd is updated.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int WIDTH  = SCORE_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  bcd_state_t          state, state_nxt;
  logic [SR_W-1:0]     sr, sr_shifted;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST_SHIFT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    logic [SR_W-1:0] adjusted;
    adjusted = sr;
    for (int d = 0; d < DIGITS; d++) begin
      adjusted[WIDTH + 4*d +: 4] = dabble_adjust(sr[WIDTH + 4*d +: 4]);
    end
    sr_shifted = {adjusted[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_LOAD: begin
          sr  <= {{(4*DIGITS){1'b0}}, bin};
          cnt <= '0;
        end
        S_SHIFT: begin
          sr  <= sr_shifted;
          cnt <= cnt + CNT_W'(1);
        end
        S_DONE:  bcd <= sr[SR_W-1:WIDTH];
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: rtl/score_bcd_keeper.sv
// Score consumer: latches the final score on gameover rise, tracks the session high score,
// and feeds the selected value to a free-running BCD converter for the display.
module score_bcd_keeper
  import score_pkg::*;
#(
  parameter int WIDTH  = SCORE_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      score,
  input  logic                  gameover,
  input  logic                  disp_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [WIDTH-1:0]      final_score,
  output logic [WIDTH-1:0]      high_score,
  output logic                  new_high
);

  logic             go_q;
  logic             frozen;
  logic             go_rise, go_fall;
  logic [WIDTH-1:0] operand;

  assign go_rise = gameover & ~go_q;
  assign go_fall = ~gameover & go_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_q        <= 1'b0;
      frozen      <= 1'b0;
      final_score <= '0;
      high_score  <= '0;
      new_high    <= 1'b0;
    end else begin
      go_q     <= gameover;
      new_high <= 1'b0;
      if (go_rise) begin
        final_score <= score;
        frozen      <= 1'b1;
        // Strict compare: tying the high score does not count as a new record.
        if (score > high_score) begin
          high_score <= score;
          new_high   <= 1'b1;
        end
      end else if (go_fall) begin
        frozen <= 1'b0;
      end
    end
  end

  // The converter samples this only in LOAD, so mid-conversion changes wait for the next run.
  assign operand = disp_sel ? high_score : (frozen ? final_score : score);

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (1'b1),
    .bin   (operand),
    .bcd   (bcd),
    .busy  (busy),
    .done  (bcd_valid)
  );

endmodule

// File: tb/tb_score_bcd_keeper.sv
// Directed bench for score_bcd_keeper: latching, high-score tracking, BCD results and timing.
module tb_score_bcd_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] score;
  logic        gameover;
  logic        disp_sel;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [15:0] final_score;
  logic [15:0] high_score;
  logic        new_high;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  always #5 clk = ~clk;

  score_bcd_keeper dut (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .gameover    (gameover),
    .disp_sel    (disp_sel),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .busy        (busy),
    .final_score (final_score),
    .high_score  (high_score),
    .new_high    (new_high)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advances to the negedge where bcd_valid is seen; returns the number of negedges waited.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bcd_valid && n < max);
    check("valid_seen", {31'd0, bcd_valid}, 32'd1);
  endtask

  task automatic wait_busy(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < max);
    check("busy_seen", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    score    = 16'd0;
    gameover = 1'b0;
    disp_sel = 1'b0;

    // 1. reset state, first result latency
    repeat (3) @(negedge clk);
    check("rst_bcd",       {12'd0, bcd},        32'h0);
    check("rst_valid",     {31'd0, bcd_valid},  32'h0);
    check("rst_busy",      {31'd0, busy},       32'h0);
    check("rst_final",     {16'd0, final_score}, 32'h0);
    check("rst_high",      {16'd0, high_score}, 32'h0);
    check("rst_new_high",  {31'd0, new_high},   32'h0);
    reset = 1'b1;
    wait_busy(5);
    wait_valid(40, cycles);
    check("first_latency", cycles, 32'd18);
    check("first_bcd",     {12'd0, bcd}, 32'h00000);

    // 2. maximum value and result spacing
    score = 16'hFFFF;
    wait_valid(40, cycles);
    check("max_period",  cycles, 32'd19);
    check("max_bcd",     {12'd0, bcd}, 32'h65535);
    wait_valid(40, cycles);
    check("max_period2", cycles, 32'd19);
    check("max_bcd2",    {12'd0, bcd}, 32'h65535);

    // 3. gameover rise latches final score and first high score
    score    = 16'd1234;
    gameover = 1'b1;
    @(negedge clk);
    check("go1_final",    {16'd0, final_score}, 32'd1234);
    check("go1_high",     {16'd0, high_score},  32'd1234);
    check("go1_new_high", {31'd0, new_high},    32'd1);
    @(negedge clk);
    check("go1_nh_pulse", {31'd0, new_high},    32'd0);
    score = 16'd900;
    wait_valid(40, cycles);
    check("frozen_bcd",   {12'd0, bcd}, 32'h01234);
    wait_valid(40, cycles);
    check("frozen_bcd2",  {12'd0, bcd}, 32'h01234);

    // 4. lower score and equal score do not set a new high
    gameover = 1'b0;
    score    = 16'd1000;
    @(negedge clk);
    check("fall_final",   {16'd0, final_score}, 32'd1234);
    gameover = 1'b1;
    @(negedge clk);
    check("go2_final",    {16'd0, final_score}, 32'd1000);
    check("go2_high",     {16'd0, high_score},  32'd1234);
    check("go2_new_high", {31'd0, new_high},    32'd0);
    @(negedge clk);
    check("go2_new_high_b", {31'd0, new_high},  32'd0);
    gameover = 1'b0;
    @(negedge clk);
    score    = 16'd1234;
    gameover = 1'b1;
    @(negedge clk);
    check("go3_final",    {16'd0, final_score}, 32'd1234);
    check("go3_high",     {16'd0, high_score},  32'd1234);
    check("go3_new_high", {31'd0, new_high},    32'd0);
    @(negedge clk);
    check("go3_new_high_b", {31'd0, new_high},  32'd0);

    // 5. disp_sel change mid-SHIFT affects only the following result
    gameover = 1'b0;
    score    = 16'd777;
    wait_valid(40, cycles);
    wait_valid(40, cycles);
    check("live_bcd",     {12'd0, bcd}, 32'h00777);
    repeat (6) @(negedge clk);
    check("mid_busy",     {31'd0, busy}, 32'd1);
    disp_sel = 1'b1;
    wait_valid(40, cycles);
    check("sel_old_bcd",  {12'd0, bcd}, 32'h00777);
    wait_valid(40, cycles);
    check("sel_high_bcd", {12'd0, bcd}, 32'h01234);
    @(negedge clk);
    check("valid_pulse",  {31'd0, bcd_valid}, 32'd0);
    check("bcd_held",     {12'd0, bcd}, 32'h01234);

    // 6. reset mid-SHIFT aborts; restart converts the live score
    repeat (5) @(negedge clk);
    disp_sel = 1'b0;
    score    = 16'd4321;
    reset    = 1'b0;
    #1;
    check("abort_bcd",    {12'd0, bcd},        32'h0);
    check("abort_valid",  {31'd0, bcd_valid},  32'h0);
    check("abort_busy",   {31'd0, busy},       32'h0);
    check("abort_high",   {16'd0, high_score}, 32'h0);
    check("abort_final",  {16'd0, final_score}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    wait_busy(5);
    wait_valid(40, cycles);
    check("restart_latency", cycles, 32'd18);
    check("restart_bcd",  {12'd0, bcd}, 32'h04321);
    check("restart_high", {16'd0, high_score}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
